audioplay_filter_ctrl: RTL and testbench
========================================

# audioplay_filter_ctrl

Filter-selection controller for the audio player. It debounces the front-panel filter switches and resolves them, or a software override, to a single filter index. It changes the audio datapath's filter select without clicks by running a gain fade-out, switch, fade-in sequence aligned to sample strobes. Software reaches it as an Avalon-MM slave beside the existing PIO inputs.

## Interface
- N_SW, 4, number of filter switch inputs (1..8)
- SELW, 3, filter select width; must satisfy 2^SELW > N_SW
- DEBOUNCE_CYC, 1000, consecutive stable clk cycles before a switch change is accepted
- STEP, 8, gain change per sample_tick during fades (1..255)

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, asynchronous assert, active-low
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- sw_in  in  N_SW  raw asynchronous filter switches
- sample_tick  in  1  one-cycle strobe per audio sample
- filt_sel  out  SELW  filter select to datapath; 0 = bypass, k = filter k
- gain  out  8  unsigned output gain to datapath, 255 = unity
- busy  out  1  high whenever state is not IDLE
- irq  out  1  switch-change interrupt (only with macro)

## Operation
- Each sw_in bit passes through a 2-flop synchronizer and a debouncer. The debounced bit updates only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- Target selection:
  - If CTRL.ovr = 1, target = CTRL.ovr_sel.
  - Otherwise target = 1 + index of the lowest set debounced bit, or 0 if no bit is set.
- State machine:
  - IDLE: if target != filt_sel, go to FADE_OUT.
  - FADE_OUT: on each sample_tick, gain = max(gain − STEP, 0). When gain reaches 0, go to SWITCH. If target becomes equal to filt_sel first, go straight to FADE_IN (abort).
  - SWITCH: lasts exactly one cycle; filt_sel <= current target; go to FADE_IN.
  - FADE_IN: on each sample_tick, gain = min(gain + STEP, 255). At 255, go to IDLE. Target changes are ignored here and re-evaluated in IDLE.
- Gain arithmetic uses 9-bit intermediates with saturation; the output never wraps.
- Register map (readdata is registered and updates one cycle after the read address):
  - 0 STATUS, read-only: [N_SW-1:0] debounced switches, [9:8] state (0 IDLE, 1 FADE_OUT, 2 SWITCH, 3 FADE_IN), [16+:SELW] filt_sel, [24+:SELW] target.
  - 1 CTRL, read/write: [0] ovr, [1] irq_mask, [8+:SELW] ovr_sel.
  - 2 GAIN, read-only: [7:0] gain.
  - 3 EDGE: reads captured edges; writing 1 to a bit clears it. Reads 0 without the macro.
- Writes to read-only addresses are ignored.

## Timing
- Reset values: readdata 0, filt_sel 0, gain 255, busy 0, irq 0, state IDLE, CTRL 0, debounced switches 0, EDGE 0.
- Reset asserted mid-fade returns everything to these values immediately; no fade-in follows.
- busy rises the cycle after IDLE detects a mismatch.
- filt_sel changes only in SWITCH, and only while gain = 0.
- A sample_tick arriving in the same cycle as the state entry is consumed by the new state.
- Software latency: a CTRL write that changes target causes busy to rise 2 cycles after the write cycle.

## Configuration
- AUDIOPLAY_FILTCTRL_IRQ_EN defined:
  - EDGE[i] sets on any change of debounced bit i.
  - irq = CTRL.irq_mask & (EDGE != 0).
  - When a set event and a W1C clear hit the same bit in the same cycle, the set wins.
- Not defined: no EDGE storage, address 3 reads 0, irq is tied to 0.

## Structure
- Package audioplay_filt_pkg holds the state enum, register address constants (REG_STATUS, REG_CTRL, REG_GAIN, REG_EDGE) and the CTRL/STATUS bit positions.
- Sub-module audioplay_debounce: synchronizer plus counter, one bit wide, instantiated N_SW times.

## Test plan
- Switch 2 held high from reset, DEBOUNCE_CYC = 16, STEP = 64 → debounced bit set after 16 + 2 cycles; gain steps 255, 191, 127, 63, 0 over 4 ticks; filt_sel = 3; gain steps 64, 128, 192, 255; busy returns to 0.
- Switch bounces with a 10-cycle period, DEBOUNCE_CYC = 16 → debounced bit never changes; no fade starts.
- Switches 1 and 3 both high → target = 2 (lowest index wins).
- CTRL write ovr = 1, ovr_sel = 5; then a switch change mid-fade → target stays 5 throughout.
- During FADE_OUT at gain 127, target reverts to filt_sel → next state is FADE_IN; gain climbs back to 255; filt_sel unchanged.
- IRQ_EN build: switch 0 toggles with irq_mask = 1 → irq asserts; W1C to EDGE bit 0 → irq deasserts the next cycle.
- Reset_n pulsed during FADE_IN → gain 255, filt_sel 0, readdata 0.

Source files
------------

// File: rtl/audioplay_filt_pkg.sv
// Shared types, register map and saturating gain helpers for the audio filter-select controller.
package audioplay_filt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } filt_state_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_GAIN   = 2'd2;
    localparam logic [1:0] REG_EDGE   = 2'd3;

    localparam int CTRL_OVR_BIT      = 0;
    localparam int CTRL_IRQ_MASK_BIT = 1;
    localparam int CTRL_OVR_SEL_LSB  = 8;

    localparam int STAT_STATE_LSB    = 8;
    localparam int STAT_FILT_SEL_LSB = 16;
    localparam int STAT_TARGET_LSB   = 24;

    // 9-bit intermediates so a step past either rail clamps instead of wrapping.
    function automatic logic [7:0] gain_down(input logic [7:0] g, input logic [7:0] s);
        logic [8:0] d;
        d = {1'b0, g} - {1'b0, s};
        return d[8] ? 8'd0 : d[7:0];
    endfunction

    function automatic logic [7:0] gain_up(input logic [7:0] g, input logic [7:0] s);
        logic [8:0] d;
        d = {1'b0, g} + {1'b0, s};
        return d[8] ? 8'hFF : d[7:0];
    endfunction

endpackage

// File: rtl/audioplay_debounce.sv
// One-bit switch conditioner: 2-flop synchronizer followed by a stable-count debouncer.
module audioplay_debounce #(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db
);

    localparam int CNTW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_reg;
    logic            db_reg;
    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
            db_reg   <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            // Any cycle where the synchronized input agrees with the output restarts the count.
            if (sync_reg[1] != db_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    db_reg  <= sync_reg[1];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNTW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign db = db_reg;

endmodule

// File: rtl/audioplay_filter_ctrl.sv
// Filter-select controller: debounced switches or software override pick a filter; changes are
// click-free via fade-out/switch/fade-in. Define AUDIOPLAY_FILTCTRL_IRQ_EN for EDGE register and irq.
module audioplay_filter_ctrl
    import audioplay_filt_pkg::*;
#(
    parameter int N_SW         = 4,
    parameter int SELW         = 3,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int STEP         = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    input  logic [N_SW-1:0] sw_in,
    input  logic            sample_tick,
    output logic [SELW-1:0] filt_sel,
    output logic [7:0]      gain,
    output logic            busy,
    output logic            irq
);

    localparam logic [7:0] STEP_G = 8'(STEP);

    logic [N_SW-1:0] db;
    logic [SELW-1:0] target;

    filt_state_t     state_reg, state_next;
    logic [7:0]      gain_reg, gain_next;
    logic [SELW-1:0] filt_sel_reg, filt_sel_next;

    logic            ctrl_ovr_reg;
    logic            irq_mask_reg;
    logic [SELW-1:0] ovr_sel_reg;
    logic [31:0]     readdata_reg;

    logic            wr_en;
    logic [31:0]     status_word;
    logic [31:0]     ctrl_word;
    logic [31:0]     edge_word;
    logic [31:0]     rd_mux;
    logic            unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
            audioplay_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (sw_in[gi]),
                .db     (db[gi])
            );
        end
    endgenerate

    // Scan from the top down so the lowest set switch is the one that sticks.
    always_comb begin
        target = '0;
        if (ctrl_ovr_reg) begin
            target = ovr_sel_reg;
        end else begin
            for (int i = N_SW - 1; i >= 0; i--) begin
                if (db[i]) begin
                    target = SELW'(i + 1);
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gain_next     = gain_reg;
        filt_sel_next = filt_sel_reg;
        case (state_reg)
            ST_IDLE: begin
                if (target != filt_sel_reg) begin
                    state_next = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                // A target that returns to the current filter cancels the fade without switching.
                if (target == filt_sel_reg) begin
                    state_next = ST_FADE_IN;
                end else if (sample_tick) begin
                    gain_next = gain_down(gain_reg, STEP_G);
                    if (gain_next == 8'd0) begin
                        state_next = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                filt_sel_next = target;
                state_next    = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (sample_tick) begin
                    gain_next = gain_up(gain_reg, STEP_G);
                    if (gain_next == 8'hFF) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            gain_reg     <= 8'hFF;
            filt_sel_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gain_reg     <= gain_next;
            filt_sel_reg <= filt_sel_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_ovr_reg <= 1'b0;
            irq_mask_reg <= 1'b0;
            ovr_sel_reg  <= '0;
        end else if (wr_en && address == REG_CTRL) begin
            ctrl_ovr_reg <= writedata[CTRL_OVR_BIT];
            irq_mask_reg <= writedata[CTRL_IRQ_MASK_BIT];
            ovr_sel_reg  <= writedata[CTRL_OVR_SEL_LSB +: SELW];
        end
    end

`ifdef AUDIOPLAY_FILTCTRL_IRQ_EN
    logic [N_SW-1:0] db_prev_reg;
    logic [N_SW-1:0] edge_reg;
    logic [N_SW-1:0] edge_clr;

    assign edge_clr = (wr_en && address == REG_EDGE) ? writedata[N_SW-1:0] : '0;

    // Set term is OR'd after the clear so a same-cycle event is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_reg <= '0;
            edge_reg    <= '0;
        end else begin
            db_prev_reg <= db;
            edge_reg    <= (edge_reg & ~edge_clr) | (db ^ db_prev_reg);
        end
    end

    always_comb begin
        edge_word           = '0;
        edge_word[N_SW-1:0] = edge_reg;
    end

    assign irq = irq_mask_reg & (|edge_reg);
`else
    assign edge_word = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        status_word                                 = '0;
        status_word[N_SW-1:0]                       = db;
        status_word[STAT_STATE_LSB +: 2]            = state_reg;
        status_word[STAT_FILT_SEL_LSB +: SELW]      = filt_sel_reg;
        status_word[STAT_TARGET_LSB +: SELW]        = target;
    end

    always_comb begin
        ctrl_word                             = '0;
        ctrl_word[CTRL_OVR_BIT]               = ctrl_ovr_reg;
        ctrl_word[CTRL_IRQ_MASK_BIT]          = irq_mask_reg;
        ctrl_word[CTRL_OVR_SEL_LSB +: SELW]   = ovr_sel_reg;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = ctrl_word;
            REG_GAIN:   rd_mux = {24'd0, gain_reg};
            REG_EDGE:   rd_mux = edge_word;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (chipselect && write_n) begin
            readdata_reg <= rd_mux;
        end
    end

    assign readdata = readdata_reg;
    assign filt_sel = filt_sel_reg;
    assign gain     = gain_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_audioplay_filter_ctrl.sv
// Scoreboard bench for audioplay_filter_ctrl: expected reads, gain steps and filter changes are
// queued by the stimulus and popped by a monitor whenever the DUT presents them.
module tb_audioplay_filter_ctrl;
    import audioplay_filt_pkg::*;

    localparam int N_SW = 4;
    localparam int SELW = 3;

    logic            clk;
    logic            reset_n;
    logic [1:0]      address;
    logic            chipselect;
    logic            write_n;
    logic [31:0]     writedata;
    logic [31:0]     readdata;
    logic [N_SW-1:0] sw_in;
    logic            sample_tick;
    logic [SELW-1:0] filt_sel;
    logic [7:0]      gain;
    logic            busy;
    logic            irq;

    audioplay_filter_ctrl #(
        .N_SW(N_SW), .SELW(SELW), .DEBOUNCE_CYC(16), .STEP(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .sw_in(sw_in),
        .sample_tick(sample_tick), .filt_sel(filt_sel), .gain(gain), .busy(busy), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } rd_t;

    rd_t        rd_q[$];
    logic [7:0] gain_q[$];
    logic [2:0] sel_q[$];

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 0;
    bit         rd_s;
    logic [7:0] last_gain;
    logic [2:0] last_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: a read sampled at a posedge is compared once readdata has registered.
    always @(posedge clk) begin
        rd_s = mon_en && chipselect && write_n;
        #2;
        if (rd_s) begin
            if (rd_q.size() == 0) fail_now("read_unexpected");
            else begin
                rd_t r;
                r = rd_q.pop_front();
                check(r.name, readdata & r.mask, r.exp & r.mask);
            end
        end
        if (mon_en && gain !== last_gain) begin
            if (gain_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL gain_unexpected actual=%h required=none", gain);
            end else check("gain_step", 32'(gain), 32'(gain_q.pop_front()));
            last_gain = gain;
        end
        if (mon_en && filt_sel !== last_sel) begin
            if (sel_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sel_unexpected actual=%h required=none", filt_sel);
            end else check("filt_sel_change", 32'(filt_sel), 32'(sel_q.pop_front()));
            last_sel = filt_sel;
        end
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (7) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] mask,
                      input string name);
        rd_t r;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        r.exp = exp; r.mask = mask; r.name = name;
        rd_q.push_back(r);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin @(negedge clk); n++; end
        if (busy) fail_now(name);
    endtask

    task automatic wait_gain(input logic [7:0] v, input string name);
        int n = 0;
        @(negedge clk);
        while (gain !== v && n < 300) begin @(negedge clk); n++; end
        if (gain !== v) fail_now(name);
    endtask

    task automatic push_fade(input bit with_in);
        gain_q.push_back(8'd191); gain_q.push_back(8'd127);
        gain_q.push_back(8'd63);  gain_q.push_back(8'd0);
        if (with_in) begin
            gain_q.push_back(8'd64);  gain_q.push_back(8'd128);
            gain_q.push_back(8'd192); gain_q.push_back(8'd255);
        end
    endtask

    initial begin
        int  n;
        bit  busy_seen;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'd0; sw_in = '0;
        repeat (3) @(negedge clk);
        check("rst_gain", 32'(gain), 32'hFF);
        check("rst_filt_sel", 32'(filt_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_readdata", readdata, 0);
        reset_n = 1'b1;
        last_gain = gain; last_sel = filt_sel; mon_en = 1'b1;
        rd(REG_STATUS, 32'h0, 32'hFFFF_FFFF, "rst_status");
        rd(REG_CTRL,   32'h0, 32'hFFFF_FFFF, "rst_ctrl");
        rd(REG_GAIN,   32'hFF, 32'hFFFF_FFFF, "rst_gain_reg");
        rd(REG_EDGE,   32'h0, 32'hFFFF_FFFF, "rst_edge");

        // Switch 2 high: debounce latency then a full fade to filter 3.
        push_fade(1); sel_q.push_back(3'd3);
        @(negedge clk); sw_in = 4'b0100;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!busy && n < 100);
        check("debounce_busy_latency", n, 19);
        wait_idle("sw2_idle");
        rd(REG_STATUS, 32'h0303_0004, 32'hFFFF_FFFF, "sw2_status");

        // Bouncing switch 1 never settles for 16 cycles.
        busy_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sw_in[1] = ~sw_in[1];
            repeat (5) begin @(negedge clk); busy_seen |= busy; end
        end
        sw_in[1] = 1'b0;
        repeat (40) begin @(negedge clk); busy_seen |= busy; end
        check("bounce_no_fade", 32'(busy_seen), 0);
        rd(REG_STATUS, 32'h0303_0004, 32'hFFFF_FFFF, "bounce_status");

        // Switches 1 and 3: lowest index wins, target 2.
        push_fade(1); sel_q.push_back(3'd2);
        @(negedge clk); sw_in = 4'b1010;
        wait_gain(8'd0, "sw13_fade");
        wait_idle("sw13_idle");
        rd(REG_STATUS, 32'h0202_000A, 32'hFFFF_FFFF, "sw13_status");

        // Override to 5; a mid-fade switch change must not move the target.
        push_fade(1); sel_q.push_back(3'd5);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = REG_CTRL; writedata = 32'h0000_0501;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        check("ovr_busy_early", 32'(busy), 0);
        @(posedge clk); #1;
        check("ovr_busy_rise", 32'(busy), 1);
        @(negedge clk); sw_in = 4'b0001;
        repeat (30) @(negedge clk);
        rd(REG_STATUS, 32'h0500_0001, 32'h0700_000F, "ovr_mid_target");
        wait_idle("ovr_idle");
        rd(REG_STATUS, 32'h0505_0001, 32'hFFFF_FFFF, "ovr_status");
        rd(REG_CTRL, 32'h0000_0501, 32'hFFFF_FFFF, "ovr_ctrl");

        // Abort: target returns to filt_sel at gain 127.
        gain_q.push_back(8'd191); gain_q.push_back(8'd127);
        gain_q.push_back(8'd191); gain_q.push_back(8'd255);
        wr(REG_CTRL, 32'h0000_0601);
        wait_gain(8'd127, "abort_reach_127");
        wr(REG_CTRL, 32'h0000_0501);
        @(negedge clk);
        rd(REG_STATUS, 32'h0505_0301, 32'hFFFF_FFFF, "abort_fade_in");
        wait_idle("abort_idle");
        check("abort_filt_sel", 32'(filt_sel), 5);
        check("abort_gain", 32'(gain), 32'hFF);

        // Reset during FADE_IN toward filter 7.
        sw_in = 4'b0000;
        push_fade(0); gain_q.push_back(8'd64); sel_q.push_back(3'd7);
        wr(REG_CTRL, 32'h0000_0701);
        wait_gain(8'd64, "fadein_reach_64");
        gain_q.push_back(8'hFF); sel_q.push_back(3'd0);
        reset_n = 1'b0;
        #1;
        check("midreset_gain", 32'(gain), 32'hFF);
        check("midreset_filt_sel", 32'(filt_sel), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_readdata", readdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postreset_busy", 32'(busy), 0);
        rd(REG_CTRL, 32'h0, 32'hFFFF_FFFF, "postreset_ctrl");
        rd(REG_STATUS, 32'h0, 32'hFFFF_FFFF, "postreset_status");

        // Read-only registers ignore writes.
        wr(REG_GAIN, 32'h0000_0012);
        rd(REG_GAIN, 32'hFF, 32'hFFFF_FFFF, "gain_ro");

`ifdef AUDIOPLAY_FILTCTRL_IRQ_EN
        wr(REG_CTRL, 32'h0000_0003);
        @(negedge clk); sw_in = 4'b0001;
        n = 0;
        while (!irq && n < 100) begin @(negedge clk); n++; end
        check("irq_assert", 32'(irq), 1);
        rd(REG_EDGE, 32'h1, 32'hFFFF_FFFF, "edge_read");
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = REG_EDGE; writedata = 32'h1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        check("irq_clear", 32'(irq), 0);
        rd(REG_EDGE, 32'h0, 32'hFFFF_FFFF, "edge_cleared");
`else
        wr(REG_EDGE, 32'h0000_000F);
        rd(REG_EDGE, 32'h0, 32'hFFFF_FFFF, "edge_absent");
        check("irq_tied", 32'(irq), 0);
`endif

        repeat (5) @(negedge clk);
        check("gain_q_drained", rd_q.size() + gain_q.size(), 0);
        check("sel_q_drained", sel_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
